alu_result_collector: RTL

- Sits on the output side of the 16-bit ALU top and reads its per-unit outputs and flags.
- Uses the opcode and an issue strobe, both presented alongside the ALU inputs, to tag each result.
- Picks the one unit output that matches the opcode and packs it with carry and opcode.
- Buffers results in a small show-ahead FIFO with a valid/ready handshake to the consumer, plus sticky overflow and protocol-error status.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_result_fifo.sv | 65 ++++++
 rtl/alu_result_collector.sv | 103 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, functional-unit select codes and default width.
// Pure declarations; no timing or flow control of its own.
package alu_pkg;

  localparam int OP_WIDTH_DEF = 16;

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_MUL    = 4'b0010,
    OP_DIV    = 4'b0011,
    OP_AND    = 4'b0100,
    OP_OR     = 4'b0101,
    OP_NAND   = 4'b0110,
    OP_NOR    = 4'b0111,
    OP_NOP    = 4'b1000,
    OP_CMP_EQ = 4'b1001,
    OP_CMP_GT = 4'b1010,
    OP_CMP_LT = 4'b1011,
    OP_SHR    = 4'b1100,
    OP_SHL    = 4'b1101,
    OP_ROR    = 4'b1110,
    OP_ROL    = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    UNIT_ARITH = 2'b00,
    UNIT_LOGIC = 2'b01,
    UNIT_CMP   = 2'b10,
    UNIT_SHIFT = 2'b11
  } alu_unit_e;

  function automatic alu_unit_e unit_of(input logic [3:0] fun);
    return alu_unit_e'(fun[3:2]);
  endfunction

  // Flag vector order is {shift, cmp, logic, arith}; exactly the selected unit is active.
  function automatic logic [3:0] unit_flag_mask(input alu_unit_e unit);
    logic [3:0] mask;
    mask = 4'b0001 << unit;
    return mask;
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Generic show-ahead FIFO; head visible the cycle after a push into an empty FIFO, no bypass.
// Full push without a same-cycle pop is dropped and reported by a one-cycle overflow pulse.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] hold_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  // A pop in the same cycle frees the slot the full-FIFO push lands in.
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & full & ~do_pop;
  // Outputs keep the last head once the FIFO drains.
  assign rdata    = empty ? hold_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (!empty) begin
        hold_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_collector.sv
// Tags ALU unit outputs with the issued opcode and queues them; entry visible two cycles after ISSUE.
// Valid/ready to the consumer; captures into a full FIFO without a pop are dropped and flagged sticky.
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int OP_WIDTH = OP_WIDTH_DEF,
  parameter int DEPTH    = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ISSUE,
  input  logic [3:0]             ALU_FUN,
  input  logic [OP_WIDTH-1:0]    Arith_OUT,
  input  logic [OP_WIDTH-1:0]    Logic_OUT,
  input  logic [OP_WIDTH-1:0]    CMP_OUT,
  input  logic [OP_WIDTH-1:0]    Shift_OUT,
  input  logic                   Carry_OUT,
  input  logic                   Arith_FLAG,
  input  logic                   Logic_FLAG,
  input  logic                   CMP_FLAG,
  input  logic                   Shift_FLAG,
  input  logic                   RES_READY,
  input  logic                   STATUS_CLR,
  output logic                   RES_VALID,
  output logic [OP_WIDTH-1:0]    RES_DATA,
  output logic                   RES_CARRY,
  output logic [3:0]             RES_FUN,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   FULL,
  output logic                   EMPTY,
  output logic                   OVERFLOW,
  output logic                   PROTO_ERR
);

  localparam int ENT_W = OP_WIDTH + 5;

  logic                issue_d;
  logic [3:0]          fun_d;
  logic [OP_WIDTH-1:0] sel_data;
  logic                sel_carry;
  logic [3:0]          unit_flags;
  logic                flag_err;
  logic                fifo_ovf;
  logic [ENT_W-1:0]    wr_ent;
  logic [ENT_W-1:0]    head_ent;

  // Unit results arrive one cycle after the opcode, so the tag is delayed to match.
  always_comb begin
    sel_data  = Arith_OUT;
    sel_carry = 1'b0;
    case (unit_of(fun_d))
      UNIT_ARITH: begin
        sel_data  = Arith_OUT;
        sel_carry = Carry_OUT;
      end
      UNIT_LOGIC: sel_data = Logic_OUT;
      UNIT_CMP:   sel_data = CMP_OUT;
      UNIT_SHIFT: sel_data = Shift_OUT;
      default:    sel_data = Arith_OUT;
    endcase
  end

  assign unit_flags = {Shift_FLAG, CMP_FLAG, Logic_FLAG, Arith_FLAG};
  assign flag_err   = issue_d & (unit_flags != unit_flag_mask(unit_of(fun_d)));
  assign wr_ent     = {sel_data, sel_carry, fun_d};

  alu_result_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (issue_d),
    .pop      (RES_READY),
    .wdata    (wr_ent),
    .rdata    (head_ent),
    .count    (COUNT),
    .full     (FULL),
    .empty    (EMPTY),
    .overflow (fifo_ovf)
  );

  assign RES_VALID = ~EMPTY;
  assign RES_DATA  = head_ent[ENT_W-1 -: OP_WIDTH];
  assign RES_CARRY = head_ent[4];
  assign RES_FUN   = head_ent[3:0];

  // A set event in the same cycle as a clear leaves the status bit set.
  always_ff @(posedge CLK) begin
    if (RST) begin
      issue_d   <= 1'b0;
      fun_d     <= 4'b0000;
      OVERFLOW  <= 1'b0;
      PROTO_ERR <= 1'b0;
    end else begin
      issue_d   <= ISSUE;
      fun_d     <= ALU_FUN;
      OVERFLOW  <= fifo_ovf | (OVERFLOW & ~STATUS_CLR);
      PROTO_ERR <= flag_err | (PROTO_ERR & ~STATUS_CLR);
    end
  end

endmodule
